// File: rtl/mc_hdr_parser.sv
// Memcached binary-protocol request header parser: decodes the 24-byte header from three
// 64-bit beats, then forwards the body. Optional statistics counters: MC_HDR_STATS_EN.
module mc_hdr_parser #(
  parameter logic [7:0] MAGIC = 8'h80,
  parameter int         CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      in_tdata,
  input  logic [7:0]       in_tkeep,
  input  logic             in_tvalid,
  input  logic             in_tlast,
  output logic             in_tready,
  output logic             hdr_valid,
  input  logic             hdr_ready,
  output logic [7:0]       hdr_opcode,
  output logic [15:0]      hdr_key_len,
  output logic [7:0]       hdr_extras_len,
  output logic [15:0]      hdr_vbucket,
  output logic [31:0]      hdr_body_len,
  output logic [31:0]      hdr_opaque,
  output logic [63:0]      hdr_cas,
  output logic [63:0]      out_tdata,
  output logic [7:0]       out_tkeep,
  output logic             out_tvalid,
  output logic             out_tlast,
  input  logic             out_tready,
  output logic             err_pulse,
  output logic             len_err_pulse,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    HDR0 = 3'd0,
    HDR1 = 3'd1,
    HDR2 = 3'd2,
    EMIT = 3'd3,
    BODY = 3'd4,
    DROP = 3'd5
  } state_t;

  state_t      state;
  logic        hdr_last;
  logic [31:0] byte_cnt;
  logic [31:0] body_sum;
  logic        beat_err;
  logic        accept;

  function automatic logic [3:0] popcount8(input logic [7:0] k);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, k[i]};
    end
    return n;
  endfunction

  // Wire order puts byte 0 in the low lane; multi-byte fields are big-endian on the wire.
  function automatic logic [63:0] bswap64(input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = d[8*(7-i) +: 8];
    end
    return r;
  endfunction

  assign accept   = in_tvalid & in_tready;
  assign body_sum = byte_cnt + {28'd0, popcount8(in_tkeep)};

  // Ready and body pass-through depend only on the current state.
  always_comb begin
    in_tready  = 1'b0;
    out_tdata  = 64'd0;
    out_tkeep  = 8'd0;
    out_tvalid = 1'b0;
    out_tlast  = 1'b0;
    if (!rst_n) begin
      in_tready = 1'b0;
    end else begin
      case (state)
        HDR0, HDR1, HDR2, DROP: in_tready = 1'b1;
        EMIT:                   in_tready = 1'b0;
        BODY: begin
          in_tready  = out_tready;
          out_tdata  = in_tdata;
          out_tkeep  = in_tkeep;
          out_tvalid = in_tvalid;
          out_tlast  = in_tlast;
        end
        default:                in_tready = 1'b0;
      endcase
    end
  end

  // A header beat is malformed on bad magic, partial keep, or an early tlast.
  always_comb begin
    beat_err = 1'b0;
    case (state)
      HDR0:    beat_err = (in_tdata[7:0] != MAGIC) || (in_tkeep != 8'hFF) || in_tlast;
      HDR1:    beat_err = (in_tkeep != 8'hFF) || in_tlast;
      HDR2:    beat_err = (in_tkeep != 8'hFF);
      default: beat_err = 1'b0;
    endcase
  end

  // Parser state machine with registered header fields and status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= HDR0;
      hdr_last       <= 1'b0;
      byte_cnt       <= 32'd0;
      hdr_valid      <= 1'b0;
      hdr_opcode     <= 8'd0;
      hdr_key_len    <= 16'd0;
      hdr_extras_len <= 8'd0;
      hdr_vbucket    <= 16'd0;
      hdr_body_len   <= 32'd0;
      hdr_opaque     <= 32'd0;
      hdr_cas        <= 64'd0;
      err_pulse      <= 1'b0;
      len_err_pulse  <= 1'b0;
    end else begin
      err_pulse     <= 1'b0;
      len_err_pulse <= 1'b0;
      case (state)
        HDR0: begin
          if (accept) begin
            hdr_opcode     <= in_tdata[15:8];
            hdr_key_len    <= {in_tdata[23:16], in_tdata[31:24]};
            hdr_extras_len <= in_tdata[39:32];
            hdr_vbucket    <= {in_tdata[55:48], in_tdata[63:56]};
            if (beat_err) begin
              err_pulse <= 1'b1;
              state     <= in_tlast ? HDR0 : DROP;
            end else begin
              state <= HDR1;
            end
          end
        end
        HDR1: begin
          if (accept) begin
            hdr_body_len <= {in_tdata[7:0], in_tdata[15:8], in_tdata[23:16], in_tdata[31:24]};
            hdr_opaque   <= in_tdata[63:32];
            if (beat_err) begin
              err_pulse <= 1'b1;
              state     <= in_tlast ? HDR0 : DROP;
            end else begin
              state <= HDR2;
            end
          end
        end
        HDR2: begin
          if (accept) begin
            hdr_cas <= bswap64(in_tdata);
            if (beat_err) begin
              err_pulse <= 1'b1;
              state     <= in_tlast ? HDR0 : DROP;
            end else begin
              hdr_valid <= 1'b1;
              hdr_last  <= in_tlast;
              state     <= EMIT;
            end
          end
        end
        EMIT: begin
          if (hdr_valid && hdr_ready) begin
            hdr_valid <= 1'b0;
            byte_cnt  <= 32'd0;
            if (hdr_last) begin
              // Header-only packet: any non-zero declared body is a length error.
              len_err_pulse <= (hdr_body_len != 32'd0);
              state         <= HDR0;
            end else begin
              state <= BODY;
            end
          end
        end
        BODY: begin
          if (accept) begin
            byte_cnt <= body_sum;
            if (in_tlast) begin
              len_err_pulse <= (body_sum != hdr_body_len);
              state         <= HDR0;
            end
          end
        end
        DROP: begin
          if (accept && in_tlast) begin
            state <= HDR0;
          end
        end
        default: state <= HDR0;
      endcase
    end
  end

`ifdef MC_HDR_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Packet and error statistics, wrapping at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt <= {CNT_W{1'b0}};
      err_cnt <= {CNT_W{1'b0}};
    end else begin
      if (hdr_valid && hdr_ready) begin
        pkt_cnt <= pkt_cnt + CNT_ONE;
      end
      if (err_pulse || len_err_pulse) begin
        err_cnt <= err_cnt + CNT_ONE;
      end
    end
  end
`else
  assign pkt_cnt = {CNT_W{1'b0}};
  assign err_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mc_hdr_parser.sv
// Directed bench for mc_hdr_parser: packet-level reference model plus per-cycle compare process.
`timescale 1ns/1ps
module tb_mc_hdr_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] in_tdata = 64'd0;
  logic [7:0]  in_tkeep = 8'd0;
  logic        in_tvalid = 1'b0;
  logic        in_tlast = 1'b0;
  logic        in_tready;
  logic        hdr_valid;
  logic        hdr_ready = 1'b1;
  logic [7:0]  hdr_opcode;
  logic [15:0] hdr_key_len;
  logic [7:0]  hdr_extras_len;
  logic [15:0] hdr_vbucket;
  logic [31:0] hdr_body_len;
  logic [31:0] hdr_opaque;
  logic [63:0] hdr_cas;
  logic [63:0] out_tdata;
  logic [7:0]  out_tkeep;
  logic        out_tvalid;
  logic        out_tlast;
  logic        out_tready = 1'b1;
  logic        err_pulse;
  logic        len_err_pulse;
  logic [31:0] pkt_cnt;
  logic [31:0] err_cnt;

  mc_hdr_parser dut (
    .clk(clk), .rst_n(rst_n),
    .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
    .in_tready(in_tready),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .hdr_opcode(hdr_opcode), .hdr_key_len(hdr_key_len), .hdr_extras_len(hdr_extras_len),
    .hdr_vbucket(hdr_vbucket), .hdr_body_len(hdr_body_len), .hdr_opaque(hdr_opaque),
    .hdr_cas(hdr_cas),
    .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tvalid(out_tvalid), .out_tlast(out_tlast),
    .out_tready(out_tready),
    .err_pulse(err_pulse), .len_err_pulse(len_err_pulse),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] key;
    logic [7:0]  ext;
    logic [15:0] vb;
    logic [31:0] blen;
    logic [31:0] opq;
    logic [63:0] cas;
  } hdr_t;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  hdr_t  exp_hdr[$];
  beat_t exp_body[$];
  hdr_t  cmp_h;
  beat_t cmp_b;

  int tests = 0;
  int fails = 0;
  int exp_err = 0;
  int exp_len = 0;
  int seen_err = 0;
  int seen_len = 0;
  int mdl_pkt = 0;
  int mdl_err = 0;
  bit tog_en = 1'b0;

  logic [63:0] pk_data[16];
  logic [7:0]  pk_keep[16];
  int          pk_n = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Build a tdata word from bytes written in wire order (leftmost byte goes first).
  function automatic logic [63:0] w8(input logic [63:0] be);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = be[8*(7-i) +: 8];
    return r;
  endfunction

  task automatic set_hdr(input logic [7:0] magic, input logic [7:0] op, input logic [15:0] key,
                         input logic [7:0] ext, input logic [31:0] blen);
    pk_data[0] = w8({magic, op, key, ext, 8'h00, 16'h1234});
    pk_data[1] = w8({blen, 32'hDEADBEEF});
    pk_data[2] = w8(64'h0102030405060708);
    for (int j = 0; j < 3; j++) pk_keep[j] = 8'hFF;
    pk_n = 3;
  endtask

  task automatic add_beat(input logic [63:0] d, input logic [7:0] k);
    pk_data[pk_n] = d;
    pk_keep[pk_n] = k;
    pk_n++;
  endtask

  // Packet-level reference: one error per malformed header, else header + body + length verdict.
  task automatic model_pkt();
    logic [7:0] b[24];
    hdr_t       h;
    beat_t      bt;
    int         sum;
    bit         bad;
    bad = (pk_n < 3) || (pk_data[0][7:0] != 8'h80);
    for (int j = 0; j < 3 && j < pk_n; j++) if (pk_keep[j] != 8'hFF) bad = 1'b1;
    if (bad) begin
      exp_err++;
      mdl_err++;
      return;
    end
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 8; i++) b[8*j+i] = pk_data[j][8*i +: 8];
    h.op   = b[1];
    h.key  = {b[2], b[3]};
    h.ext  = b[4];
    h.vb   = {b[6], b[7]};
    h.blen = {b[8], b[9], b[10], b[11]};
    h.opq  = {b[15], b[14], b[13], b[12]};
    h.cas  = {b[16], b[17], b[18], b[19], b[20], b[21], b[22], b[23]};
    exp_hdr.push_back(h);
    mdl_pkt++;
    sum = 0;
    for (int j = 3; j < pk_n; j++) begin
      bt.d = pk_data[j];
      bt.k = pk_keep[j];
      bt.l = (j == pk_n - 1);
      exp_body.push_back(bt);
      sum += $countones(pk_keep[j]);
    end
    if (32'(sum) != h.blen) begin
      exp_len++;
      mdl_err++;
    end
  endtask

  // Called at posedge+1; each beat is held until in_tready is seen high mid-cycle.
  task automatic send_beats(input int lo, input int hi);
    int cyc;
    bit hs;
    for (int j = lo; j <= hi; j++) begin
      in_tdata  = pk_data[j];
      in_tkeep  = pk_keep[j];
      in_tlast  = (j == pk_n - 1);
      in_tvalid = 1'b1;
      cyc = 0;
      hs  = 1'b0;
      while (!hs && cyc < 200) begin
        @(negedge clk);
        hs = in_tready;
        cyc++;
        @(posedge clk);
        #1;
      end
      if (!hs) begin
        tests++;
        fails++;
        $display("FAIL beat_timeout: beat %0d not accepted, waited %0d cycles, required < 200", j, cyc);
      end
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic send_pkt();
    model_pkt();
    send_beats(0, pk_n - 1);
  endtask

  task automatic check_end(input string tag);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_hdr_pending"}, 64'(exp_hdr.size()), 64'd0);
    check({tag, "_body_pending"}, 64'(exp_body.size()), 64'd0);
    check({tag, "_err_pulses"}, 64'(seen_err), 64'(exp_err));
    check({tag, "_len_err_pulses"}, 64'(seen_len), 64'(exp_len));
`ifdef MC_HDR_STATS_EN
    check({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(mdl_pkt));
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'(mdl_err));
`else
    check({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'd0);
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
`endif
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_in_tready", 64'(in_tready), 64'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_tready", 64'(in_tready), 64'd1);
    check("post_rst_hdr_valid", 64'(hdr_valid), 64'd0);
    check("post_rst_err_pulse", 64'({err_pulse, len_err_pulse}), 64'd0);
    check("post_rst_hdr_cas", hdr_cas, 64'd0);
    check("post_rst_body_len", 64'(hdr_body_len), 64'd0);
    check("post_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("post_rst_err_cnt", 64'(err_cnt), 64'd0);
    @(posedge clk);
    #1;
    exp_hdr.delete();
    exp_body.delete();
    mdl_pkt = 0;
    mdl_err = 0;
  endtask

  // Compare process: header handshakes and body beats against the model queues, every cycle.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (err_pulse) seen_err++;
      if (len_err_pulse) seen_len++;
      if (hdr_valid && hdr_ready) begin
        if (exp_hdr.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_hdr: hdr handshake with opcode %0h, required none", hdr_opcode);
        end else begin
          cmp_h = exp_hdr.pop_front();
          check("hdr_opcode", 64'(hdr_opcode), 64'(cmp_h.op));
          check("hdr_key_len", 64'(hdr_key_len), 64'(cmp_h.key));
          check("hdr_extras_len", 64'(hdr_extras_len), 64'(cmp_h.ext));
          check("hdr_vbucket", 64'(hdr_vbucket), 64'(cmp_h.vb));
          check("hdr_body_len", 64'(hdr_body_len), 64'(cmp_h.blen));
          check("hdr_opaque", 64'(hdr_opaque), 64'(cmp_h.opq));
          check("hdr_cas", hdr_cas, cmp_h.cas);
        end
      end
      if (out_tvalid && out_tready) begin
        if (exp_body.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_body: out beat %0h keep %0h, required none", out_tdata, out_tkeep);
        end else begin
          cmp_b = exp_body.pop_front();
          check("out_tdata", out_tdata, cmp_b.d);
          check("out_tkeep", 64'(out_tkeep), 64'(cmp_b.k));
          check("out_tlast", 64'(out_tlast), 64'(cmp_b.l));
        end
      end
    end
  end

  // out_tready is either held high or toggled every cycle.
  initial forever begin
    @(posedge clk);
    #1;
    out_tready = tog_en ? ~out_tready : 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Valid GET with a 5-byte body.
    set_hdr(8'h80, 8'h00, 16'h0005, 8'h00, 32'd5);
    add_beat(w8(64'h68656C6C6F000000), 8'h1F);
    model_pkt();
    send_beats(0, 2);
    @(negedge clk);
    check("get_hdr_valid_latency", 64'(hdr_valid), 64'd1);
    check("get_key_len", 64'(hdr_key_len), 64'd5);
    check("get_opaque_raw", 64'(hdr_opaque), 64'hEFBEADDE);
    check("get_cas", hdr_cas, 64'h0102030405060708);
    check("get_vbucket", 64'(hdr_vbucket), 64'h1234);
    check("get_emit_in_tready", 64'(in_tready), 64'd0);
    @(posedge clk);
    #1;
    send_beats(3, 3);
    check_end("get");
    check("get_no_errors", 64'(seen_err + seen_len), 64'd0);

    // Bad magic in a 5-beat packet, then a good packet.
    set_hdr(8'h81, 8'h00, 16'h0002, 8'h00, 32'd16);
    add_beat(64'h1111111111111111, 8'hFF);
    add_beat(64'h2222222222222222, 8'hFF);
    send_pkt();
    set_hdr(8'h80, 8'h01, 16'h0003, 8'h00, 32'd3);
    add_beat(64'h0000000000ABCDEF, 8'h07);
    send_pkt();
    check_end("magic");
    check("magic_one_err", 64'(seen_err), 64'd1);

    // Truncated header: tlast on the second beat.
    set_hdr(8'h80, 8'h00, 16'h0001, 8'h00, 32'd0);
    pk_n = 2;
    send_pkt();
    set_hdr(8'h80, 8'h0A, 16'h0010, 8'h04, 32'd8);
    add_beat(64'h0123456789ABCDEF, 8'hFF);
    send_pkt();
    check_end("trunc");
    check("trunc_err_total", 64'(seen_err), 64'd2);

    // Declared 16 bytes, 12 delivered.
    set_hdr(8'h80, 8'h01, 16'h0004, 8'h04, 32'd16);
    add_beat(64'hCAFEF00DCAFEF00D, 8'hFF);
    add_beat(64'h00000000A5A5A5A5, 8'h0F);
    send_pkt();
    check_end("lenerr");
    check("lenerr_total", 64'(seen_len), 64'd1);

    // Consumer stalls the header for 10 cycles; body then crosses a toggling out_tready.
    hdr_ready = 1'b0;
    set_hdr(8'h80, 8'h02, 16'h0007, 8'h08, 32'd20);
    add_beat(64'h1010101010101010, 8'hFF);
    add_beat(64'h2020202020202020, 8'h00);
    add_beat(64'h3030303030303030, 8'hFF);
    add_beat(64'h0000000040404040, 8'h0F);
    model_pkt();
    send_beats(0, 2);
    in_tdata  = pk_data[3];
    in_tkeep  = pk_keep[3];
    in_tvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_hdr_valid", 64'(hdr_valid), 64'd1);
      check("stall_in_tready", 64'(in_tready), 64'd0);
      check("stall_out_tvalid", 64'(out_tvalid), 64'd0);
      check("stall_fields", {hdr_key_len, hdr_extras_len, hdr_body_len[7:0], hdr_opcode, 24'd0},
            {16'd7, 8'd8, 8'd20, 8'h02, 24'd0});
      @(posedge clk);
      #1;
    end
    hdr_ready = 1'b1;
    tog_en    = 1'b1;
    send_beats(3, pk_n - 1);
    tog_en = 1'b0;
    check_end("stall");

    // Header-only packets back to back: zero body length is fine, non-zero is a length error.
    set_hdr(8'h80, 8'h03, 16'h0000, 8'h00, 32'd0);
    send_pkt();
    set_hdr(8'h80, 8'h04, 16'h0000, 8'h00, 32'd4);
    send_pkt();
    check_end("hdronly");
    check("hdronly_len_total", 64'(seen_len), 64'd2);

    // Partial keep on the third header beat drops the packet.
    set_hdr(8'h80, 8'h05, 16'h0002, 8'h00, 32'd8);
    pk_keep[2] = 8'h7F;
    add_beat(64'h5555555555555555, 8'hFF);
    send_pkt();
    set_hdr(8'h80, 8'h06, 16'h0002, 8'h00, 32'd2);
    add_beat(64'h0000000000007777, 8'h03);
    send_pkt();
    check_end("keep");
    check("keep_err_total", 64'(seen_err), 64'd3);

    // Reset in the middle of a body.
    set_hdr(8'h80, 8'h07, 16'h0001, 8'h00, 32'd16);
    add_beat(64'h6666666666666666, 8'hFF);
    add_beat(64'h7777777777777777, 8'hFF);
    model_pkt();
    send_beats(0, 3);
    do_reset();

    // Statistics: three good packets and two bad ones since the last reset.
    for (int p = 0; p < 5; p++) begin
      set_hdr((p % 2 == 1) ? 8'h00 : 8'h80, 8'(p), 16'h0001, 8'h00, 32'd1);
      add_beat(64'(p), 8'h01);
      send_pkt();
    end
    check_end("stats");
`ifdef MC_HDR_STATS_EN
    check("stats_pkt_literal", 64'(pkt_cnt), 64'd3);
    check("stats_err_literal", 64'(err_cnt), 64'd2);
`else
    check("stats_pkt_literal", 64'(pkt_cnt), 64'd0);
    check("stats_err_literal", 64'(err_cnt), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mc_hdr_parser.md
Name: mc_hdr_parser

Overview:
- Downstream consumer of the 64-bit AXI-Stream memcached request generator; parses the 24-byte memcached binary-protocol request header from the first three beats of each packet.
- Presents decoded header fields on a valid/ready side channel, then forwards the body (extras+key+value) as an AXI-Stream.
- Validates magic, header completeness and body length; malformed packets are dropped and flagged.

Parameters:
- MAGIC, 8'h80, required value of header byte 0 (request magic)
- CNT_W, 32, width of statistics counters

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_tdata  in  64  stream data; byte i = in_tdata[8i+7:8i], byte 0 first on wire
- in_tkeep  in  8  byte enables, bit i qualifies byte i
- in_tvalid / in_tlast  in  1 / 1  stream valid / last
- in_tready  out  1  stream ready
- hdr_valid  out  1  header fields valid
- hdr_ready  in  1  header consumer ready
- hdr_opcode  out  8  byte 1
- hdr_key_len  out  16  bytes 2-3, big-endian
- hdr_extras_len  out  8  byte 4
- hdr_vbucket  out  16  bytes 6-7, big-endian
- hdr_body_len  out  32  bytes 8-11, big-endian
- hdr_opaque  out  32  bytes 12-15, raw
- hdr_cas  out  64  bytes 16-23, big-endian
- out_tdata / out_tkeep / out_tvalid / out_tlast  out  64/8/1/1  body stream
- out_tready  in  1  body stream ready
- err_pulse  out  1  one-cycle pulse per header error
- len_err_pulse  out  1  one-cycle pulse on body-length mismatch
- pkt_cnt / err_cnt  out  CNT_W each  statistics (see Optional Feature)

Behaviour:
- Reset: state HDR0; all outputs 0 (hdr fields, pulses, counters); in_tready 0 during reset, 1 in first cycle after.
- States: HDR0, HDR1, HDR2, EMIT, BODY, DROP. Reset mid-packet → HDR0 immediately; remaining beats of that packet parse as a new header (expected to fail magic).
- HDR0/HDR1/HDR2: in_tready=1; beat accepted on in_tvalid. Fields captured into registers on acceptance.
- Header error: HDR0 byte0≠MAGIC; any header beat with tkeep≠8'hFF; tlast on HDR0 or HDR1 beat. On error: err_pulse=1 next cycle, no hdr_valid. Go DROP if offending beat lacks tlast, else HDR0.
- DROP: in_tready=1, discard beats up to and including tlast, then HDR0.
- HDR2 accepted cleanly → EMIT next cycle (1-cycle latency from final header beat to hdr_valid). Remember whether the HDR2 beat carried tlast.
- EMIT: hdr_valid=1, fields stable, in_tready=0. On hdr_valid&hdr_ready: if HDR2 had tlast → HDR0 (len_err_pulse if hdr_body_len≠0), else BODY. hdr_valid deasserts in the following cycle.
- BODY: combinational pass-through: out_t* = in_t*, out_tvalid=in_tvalid, in_tready=out_tready. Byte counter (32 bit, cleared at EMIT exit) adds popcount(in_tkeep) per accepted beat. On the accepted tlast beat: compare counter+popcount with hdr_body_len, pulse len_err_pulse on mismatch, return to HDR0. Body is forwarded regardless of mismatch.
- out_tvalid=0 outside BODY. Body beats with tkeep=0 are forwarded and add 0.
- Back-to-back packets: HDR0 accepts the cycle after the last BODY beat or the EMIT handshake; no idle cycle required from the upstream.

Optional Feature:
- MC_HDR_STATS_EN defined: pkt_cnt increments at each hdr_valid&hdr_ready handshake; err_cnt increments on each err_pulse or len_err_pulse (by 1 if both fire in one cycle, cannot occur); both wrap at 2^CNT_W; cleared by reset.
- Undefined: pkt_cnt and err_cnt tied to 0, no counter logic.

Test Plan:
- Valid GET: 3 header beats (magic 80, opcode 00, key_len 0005, body_len 00000005) + 1 body beat tkeep 8'h1F, tlast → hdr_valid 1 cycle after beat 3, hdr_key_len=5, one out beat tkeep 1F tlast, no error pulses.
- Bad magic 0x81 in 5-beat packet → err_pulse once, no hdr_valid, no out_tvalid, all 5 beats consumed, next valid packet parses correctly.
- tlast on beat 2 (truncated header) → err_pulse, state HDR0, following packet parses correctly.
- hdr_body_len=16, actual body 12 bytes (8'hFF, 8'h0F) → body forwarded unchanged, len_err_pulse on last beat.
- hdr_ready held low 10 cycles in EMIT → in_tready=0 and fields stable throughout; out_tready toggling in BODY → no lost/duplicated beats.
- MC_HDR_STATS_EN: 3 good + 2 bad packets → pkt_cnt=3, err_cnt=2; reset mid-body → counters 0, in_tready=1 the cycle after reset deasserts.
